// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-cycle fetch into an instruction
// register, branch squash, halt detection and a saturating retire counter.
module fetch_unit #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [2:0]         opcode,
    output logic [2:0]         typeselect,
    output logic [2:0]         operand,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic               done,
    output logic [15:0]        instr_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [PC_W-1:0]     pc_out_reg, pc_out_next;
    logic                valid_reg, valid_next;
    logic [15:0]         count_reg, count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            instr_reg  <= '0;
            pc_out_reg <= '0;
            valid_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            pc_out_reg <= pc_out_next;
            valid_reg  <= valid_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        pc_out_next = pc_out_reg;
        valid_next  = valid_reg;
        count_next  = count_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    pc_next    = start_addr;
                    valid_next = 1'b0;
                    count_next = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (valid_reg && instr_reg == HALT_WORD) begin
                        // Halt retires without counting and freezes the PC.
                        state_next = S_DONE;
                        valid_next = 1'b0;
                    end else begin
                        if (valid_reg && count_reg != 16'hFFFF)
                            count_next = count_reg + 16'd1;
                        if (valid_reg && branch_taken) begin
                            // Drop the fetch already in flight behind the branch.
                            pc_next    = branch_target;
                            valid_next = 1'b0;
                        end else begin
                            instr_next  = imem_data;
                            pc_out_next = pc_reg;
                            valid_next  = 1'b1;
                            pc_next     = pc_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_addr   = pc_reg;
    assign opcode      = instr_reg[INSTR_W-1 -: 3];
    assign typeselect  = instr_reg[INSTR_W-4 -: 3];
    assign operand     = instr_reg[2:0];
    assign instr_valid = valid_reg;
    assign pc_out      = pc_out_reg;
    assign done        = (state_reg == S_DONE);
    assign instr_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset, start, stall, branch_taken;
    logic [9:0]  start_addr, branch_target, imem_addr, pc_out;
    logic [8:0]  imem_data;
    logic [2:0]  opcode, typeselect, operand;
    logic        instr_valid, done;
    logic [15:0] instr_count;

    logic [8:0] mem [0:1023];
    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .opcode(opcode),
        .typeselect(typeselect), .operand(operand), .instr_valid(instr_valid),
        .pc_out(pc_out), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 running, 2 finished
    int          m_mode;
    logic [9:0]  m_pc, m_pcout;
    logic [8:0]  m_word;
    logic        m_valid;
    int          m_retired;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_pcout = 0; m_word = 0; m_valid = 0; m_retired = 0;
    endtask

    // One rising edge of the architectural behaviour, in terms of retire events.
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = start_addr; m_valid = 0; m_retired = 0;
            end
        end else if (!stall) begin
            if (m_valid && m_word == HALT) begin
                m_mode = 2;
                m_valid = 0;
            end else begin
                if (m_valid) m_retired = (m_retired < 65535) ? m_retired + 1 : 65535;
                if (m_valid && branch_taken) begin
                    m_pc = branch_target;
                    m_valid = 0;
                end else begin
                    m_word  = mem[m_pc];
                    m_pcout = m_pc;
                    m_valid = 1;
                    m_pc    = 10'((int'(m_pc) + 1) % 1024);
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("pc_out", 32'(pc_out), 32'(m_pcout));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_count", 32'(instr_count), 32'(m_retired));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("fields", 32'({opcode, typeselect, operand}), 32'(m_word));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; branch_taken = 0;
    endtask

    typedef struct {
        logic        st;
        logic [9:0]  sa;
        logic        sl;
        logic        br;
        logic [9:0]  bt;
        logic        ev;
        logic [9:0]  epc;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt [14];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 37 + 5) % 511);
        mem[10'h3FF] = HALT;

        vt[0]  = '{1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 16'd0};
        vt[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h010, 16'd0};
        vt[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h011, 16'd1};
        vt[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h012, 16'd2};
        vt[4]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h080, 1'b0, 10'h012, 16'd3};
        vt[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h080, 16'd3};
        vt[6]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h081, 16'd4};
        vt[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 1'b1, 10'h081, 16'd4};
        vt[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 1'b1, 10'h081, 16'd4};
        vt[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 1'b1, 10'h081, 16'd4};
        vt[10] = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h200, 1'b0, 10'h081, 16'd5};
        vt[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h200, 16'd5};
        vt[12] = '{1'b1, 10'h300, 1'b0, 1'b0, 10'h000, 1'b1, 10'h201, 16'd6};
        vt[13] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h202, 16'd7};

        reset = 1; idle_inputs(); start_addr = 0; branch_target = 0;
        model_reset();
        tick(); tick();
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_pc", 32'(imem_addr), 32'd0);
        reset = 0;

        // Directed table: sequential fetch, branch, stalled branch, start in RUN
        for (int i = 0; i < 14; i++) begin
            start = vt[i].st; start_addr = vt[i].sa; stall = vt[i].sl;
            branch_taken = vt[i].br; branch_target = vt[i].bt;
            tick();
            chk("vec_valid", 32'(instr_valid), 32'(vt[i].ev));
            chk("vec_pc_out", 32'(pc_out), 32'(vt[i].epc));
            chk("vec_count", 32'(instr_count), 32'(vt[i].ecnt));
            if (vt[i].ev)
                chk("vec_fields", 32'({opcode, typeselect, operand}), 32'(mem[vt[i].epc]));
            $display("vec %0d pc_out=%03h valid=%b count=%0d", i, pc_out, instr_valid, instr_count);
        end
        idle_inputs();

        // Async reset between edges, then restart
        @(posedge clk); model_step(); #3;
        reset = 1; #1;
        model_reset();
        chk("async_pc_out", 32'(pc_out), 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_count", 32'(instr_count), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'd0);
        chk("async_fields", 32'({opcode, typeselect, operand}), 32'd0);
        @(negedge clk); reset = 0;
        tick();
        chk("post_reset_idle", 32'(instr_valid), 32'd0);
        $display("seq async_reset pc_out=%03h valid=%b", pc_out, instr_valid);

        // Halt at top of memory with wrap squashed
        start = 1; start_addr = 10'h3FE; tick(); start = 0;
        tick(); chk("halt_pc0", 32'(pc_out), 32'h3FE);
        tick(); chk("halt_pc1", 32'(pc_out), 32'h3FF);
        chk("halt_word", 32'({opcode, typeselect, operand}), 32'h1FF);
        branch_taken = 1; branch_target = 10'h155;
        tick(); branch_taken = 0;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_count", 32'(instr_count), 32'd1);
        chk("halt_pc_frozen", 32'(imem_addr), 32'h000);
        tick(); chk("halt_hold", 32'(imem_addr), 32'h000);
        $display("seq halt done=%b count=%0d", done, instr_count);

        // Restart from DONE; branch while nothing valid must be ignored
        start = 1; start_addr = 10'h020; tick(); start = 0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_count", 32'(instr_count), 32'd0);
        branch_taken = 1; branch_target = 10'h100;
        tick(); branch_taken = 0;
        chk("nobranch_pc", 32'(pc_out), 32'h020);
        tick(); chk("nobranch_next", 32'(pc_out), 32'h021);
        $display("seq restart pc_out=%03h count=%0d", pc_out, instr_count);

        // Randomized traffic with sprinkled halts
        for (int i = 0; i < 24; i++) mem[$urandom_range(0, 1022)] = HALT;
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 499) == 0);
            start         = ($urandom_range(0, 39) == 0);
            start_addr    = 10'($urandom);
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_target = 10'($urandom);
            tick();
        end
        reset = 0; idle_inputs();
        $display("seq random cycles=3000");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
